// File: rtl/world.sv
// ============================================================================
// Module   : world
// Function : Left-hand-rule maze robot on a fixed 10x20 wall map, plus a
//            640x480 VGA renderer showing the map and the robot position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module world #(
  parameter int STEP_CYCLES = 2
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic [1:6] robot_row,
  output logic [1:6] robot_column,
  output logic [2:0] robot_orientation
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [1:0] {
    NORTH = 2'b00,
    SOUTH = 2'b01,
    EAST  = 2'b10,
    WEST  = 2'b11
  } heading_t;

  logic           clk;
  logic           rst_n;
  logic           unused_keys;
  logic [CW-1:0]  step_cnt;
  logic           step_pulse;
  logic [5:0]     row;
  logic [5:0]     col;
  heading_t       dir;
  heading_t       left_dir;
  logic [5:0]     ahead_row;
  logic [5:0]     ahead_col;
  logic [5:0]     left_row;
  logic [5:0]     left_col;
  logic           head_wall;
  logic           left_wall;
  logic           pix_en;
  logic [9:0]     h_cnt;
  logic [9:0]     v_cnt;
  logic [5:0]     cell_row;
  logic [5:0]     cell_col;
  logic [23:0]    pix_rgb;

  assign clk         = CLOCK_50;
  assign rst_n       = KEY[0];
  assign unused_keys = ^KEY[3:1];

  // Any coordinate off the 10x20 map counts as wall, so the sensors need
  // no separate edge handling.
  function automatic logic is_wall(input logic [5:0] r, input logic [5:0] c);
    return (r < 6'd1) || (r > 6'd10) || (c < 6'd1) || (c > 6'd20) ||
           (r == 6'd5 && c >= 6'd3 && c <= 6'd17) ||
           (c == 6'd10 && r >= 6'd7 && r <= 6'd9);
  endfunction

  function automatic logic [5:0] step_row(input heading_t h, input logic [5:0] r);
    case (h)
      NORTH:   return r - 6'd1;
      SOUTH:   return r + 6'd1;
      default: return r;
    endcase
  endfunction

  function automatic logic [5:0] step_col(input heading_t h, input logic [5:0] c);
    case (h)
      EAST:    return c + 6'd1;
      WEST:    return c - 6'd1;
      default: return c;
    endcase
  endfunction

  function automatic heading_t left_of(input heading_t h);
    case (h)
      NORTH:   return WEST;
      WEST:    return SOUTH;
      SOUTH:   return EAST;
      default: return NORTH;
    endcase
  endfunction

  function automatic heading_t right_of(input heading_t h);
    case (h)
      NORTH:   return EAST;
      EAST:    return SOUTH;
      SOUTH:   return WEST;
      default: return NORTH;
    endcase
  endfunction

  // Sensors are purely combinational from the current pose
  assign left_dir  = left_of(dir);
  assign ahead_row = step_row(dir, row);
  assign ahead_col = step_col(dir, col);
  assign left_row  = step_row(left_dir, row);
  assign left_col  = step_col(left_dir, col);
  assign head_wall = is_wall(ahead_row, ahead_col);
  assign left_wall = is_wall(left_row, left_col);

  assign step_pulse = (step_cnt == CW'(STEP_CYCLES - 1));

  // Step-enable divider: one pulse every STEP_CYCLES clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (step_pulse) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + CW'(1);
    end
  end

  // Robot pose: one left-hand-rule action per step pulse, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 6'd10;
      col <= 6'd1;
      dir <= NORTH;
    end else if (step_pulse) begin
      if (!left_wall) begin
        dir <= left_dir;
        row <= left_row;
        col <= left_col;
      end else if (!head_wall) begin
        row <= ahead_row;
        col <= ahead_col;
      end else begin
        dir <= right_of(dir);
      end
    end
  end

  assign robot_row         = row;
  assign robot_column      = col;
  assign robot_orientation = {1'b0, dir};

  // Pixel enable toggles every clock; raster counters advance on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == 10'd799) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Each map cell covers 32 pixels across and 48 lines down
  assign cell_col = {1'b0, h_cnt[9:5]} + 6'd1;
  assign cell_row = 6'(v_cnt / 10'd48) + 6'd1;

  // Colour of the current raster position; robot overrides the map
  always_comb begin
    pix_rgb = 24'h000000;
    if (h_cnt < 10'd640 && v_cnt < 10'd480) begin
      if (cell_row == row && cell_col == col) begin
        pix_rgb = 24'hFF0000;
      end else if (is_wall(cell_row, cell_col)) begin
        pix_rgb = 24'h808080;
      end else begin
        pix_rgb = 24'hFFFFFF;
      end
    end
  end

  // Sync and colour registered together from the same raster position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_R  <= 8'h00;
      VGA_G  <= 8'h00;
      VGA_B  <= 8'h00;
    end else begin
      VGA_HS <= !(h_cnt >= 10'd656 && h_cnt < 10'd752);
      VGA_VS <= !(v_cnt >= 10'd490 && v_cnt < 10'd492);
      VGA_R  <= pix_rgb[23:16];
      VGA_G  <= pix_rgb[15:8];
      VGA_B  <= pix_rgb[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_world.sv
// ============================================================================
// Module   : tb_world
// Function : Self-checking bench for world: table vectors for the opening
//            trajectory, a pose/raster reference model checked every clock,
//            random resets and random don't-care keys.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_world;

  localparam int STEP = 2;

  logic       clk;
  logic [3:0] key;
  logic       hs;
  logic       vs;
  logic [7:0] vr;
  logic [7:0] vg;
  logic [7:0] vb;
  logic [1:6] row;
  logic [1:6] col;
  logic [2:0] ori;

  world #(.STEP_CYCLES(STEP)) dut (
    .CLOCK_50          (clk),
    .KEY               (key),
    .VGA_HS            (hs),
    .VGA_VS            (vs),
    .VGA_R             (vr),
    .VGA_G             (vg),
    .VGA_B             (vb),
    .robot_row         (row),
    .robot_column      (col),
    .robot_orientation (ori)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: heading 0=N 1=S 2=E 3=W
  bit wallmap [0:11][0:21];
  int dr [4] = '{-1, 1, 0, 0};
  int dc [4] = '{0, 0, 1, -1};
  int lft [4] = '{3, 2, 0, 1};
  int rgt [4] = '{2, 3, 1, 0};
  int m_row, m_col, m_dir, p_row, p_col;
  int n;

  typedef struct {
    int step;
    int row;
    int col;
    int ori;
  } vec_t;
  vec_t tbl [10];

  task automatic check(string tag, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s n=%0d actual=%h required=%h", tag, n, act, req);
    end
  endtask

  task automatic model_reset();
    m_row = 10; m_col = 1; m_dir = 0;
    p_row = 10; p_col = 1;
    n = 0;
  endtask

  task automatic model_step();
    int lr, lc, ar, ac;
    lr = m_row + dr[lft[m_dir]];
    lc = m_col + dc[lft[m_dir]];
    ar = m_row + dr[m_dir];
    ac = m_col + dc[m_dir];
    if (!wallmap[lr][lc]) begin
      m_dir = lft[m_dir]; m_row = lr; m_col = lc;
    end else if (!wallmap[ar][ac]) begin
      m_row = ar; m_col = ac;
    end else begin
      m_dir = rgt[m_dir];
    end
  endtask

  // Compare every output against the model for the current clock count
  task automatic check_all(string tag);
    int p, h, v, rr, cc;
    logic hs_e, vs_e;
    logic [23:0] rgb;
    if (n == 0) begin
      hs_e = 1'b1; vs_e = 1'b1; rgb = 24'h0;
    end else begin
      p = (n - 1) / 2;
      h = p % 800;
      v = (p / 800) % 525;
      hs_e = !(h >= 656 && h < 752);
      vs_e = !(v >= 490 && v < 492);
      if (h < 640 && v < 480) begin
        cc = h / 32 + 1;
        rr = v / 48 + 1;
        if (rr == p_row && cc == p_col) rgb = 24'hFF0000;
        else if (wallmap[rr][cc])       rgb = 24'h808080;
        else                            rgb = 24'hFFFFFF;
      end else begin
        rgb = 24'h0;
      end
    end
    check(tag, {23'd0, row, col, ori, hs, vs, vr, vg, vb},
          {23'd0, 6'(m_row), 6'(m_col), 3'(m_dir), hs_e, vs_e, rgb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    key[3:1] = 3'($urandom);
    n++;
    p_row = m_row;
    p_col = m_col;
    if (n % STEP == 0) model_step();
    check_all("model");
  endtask

  // Assert reset off-edge, check it took effect without a clock, then release
  task automatic do_reset(int dly);
    #(dly);
    key[0] = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("held_reset");
    @(negedge clk);
    key[0] = 1'b1;
  endtask

  initial begin
    logic prev_hs;
    int   last_fall;

    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 22; c++)
        wallmap[r][c] = (r < 1 || r > 10 || c < 1 || c > 20);
    for (int c = 3; c <= 17; c++) wallmap[5][c] = 1'b1;
    for (int r = 7; r <= 9; r++) wallmap[r][10] = 1'b1;

    tbl[0] = '{0, 10, 1, 0};
    tbl[1] = '{1, 9, 1, 0};
    tbl[2] = '{5, 5, 1, 0};
    tbl[3] = '{9, 1, 1, 0};
    tbl[4] = '{10, 1, 1, 2};
    tbl[5] = '{11, 1, 2, 2};
    tbl[6] = '{20, 1, 11, 2};
    tbl[7] = '{29, 1, 20, 2};
    tbl[8] = '{30, 1, 20, 1};
    tbl[9] = '{31, 2, 20, 1};

    key = 4'b1111;
    model_reset();
    do_reset(3);

    // Opening trajectory: climb, corner turn, run east, turn south
    for (int i = 0; i < 10; i++) begin
      while (n < tbl[i].step * STEP) tick();
      check($sformatf("vec%0d", i), {58'd0, row, col, ori},
            {58'd0, 6'(tbl[i].row), 6'(tbl[i].col), 3'(tbl[i].ori)});
    end

    // Reset 37 clocks into a run
    do_reset(2);
    repeat (37) tick();
    do_reset(2);

    // Random run lengths with random off-edge reset points
    for (int k = 0; k < 5; k++) begin
      int len;
      len = int'($urandom_range(5, 300));
      repeat (len) tick();
      do_reset(int'($urandom_range(1, 3)));
    end

    // Long run: model every clock, pose invariants, HS timing
    prev_hs   = 1'b1;
    last_fall = -1;
    repeat (60000) begin
      tick();
      check("pose_legal",
            {63'd0, (row >= 1 && row <= 10 && col >= 1 && col <= 20 && ori < 3'd4)
                    ? !wallmap[row][col] : 1'b0},
            64'd1);
      if (prev_hs && !hs) begin
        if (last_fall >= 0) check("hs_period", 64'(n - last_fall), 64'd1600);
        last_fall = n;
      end
      if (!prev_hs && hs && last_fall >= 0) check("hs_low", 64'(n - last_fall), 64'd192);
      prev_hs = hs;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
